// File: rtl/cpu_bus_tracer.sv
// CPU bus tracer: snoops the bus, counts read/write/illegal cycles, traces them into a FIFO
// and stops on a cycle limit or watch hit. Optional timestamp prefix via TRACE_TIMESTAMP_EN.
module cpu_bus_tracer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int NUM_WATCH = 2,
    parameter int CNT_W     = 32,
    parameter int TS_W      = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W  = TS_W + 2 + ADDR_W + DATA_W
`else
    localparam int ENTRY_W  = 2 + ADDR_W + DATA_W
`endif
) (
    input  logic                        clkR,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           ADDRBUS,
    input  logic [1:0]                  CTRLBUS,
    input  logic [DATA_W-1:0]           DATABUS,
    input  logic                        arm,
    input  logic [CNT_W-1:0]            cycle_limit,
    input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
    input  logic [NUM_WATCH-1:0]        watch_en,
    input  logic                        halt_on_watch,
    input  logic                        trace_rd,
    output logic                        trace_valid,
    output logic [ENTRY_W-1:0]          trace_data,
    output logic                        trace_empty,
    output logic                        overflow,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            wr_count,
    output logic [CNT_W-1:0]            err_count,
    output logic [NUM_WATCH-1:0]        watch_hit,
    output logic                        running,
    output logic                        done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cyc;
    logic [CNT_W-1:0]     r_rd_count;
    logic [CNT_W-1:0]     r_wr_count;
    logic [CNT_W-1:0]     r_err_count;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic                 r_overflow;
    logic [NUM_WATCH-1:0] r_watch_hit;
    logic                 r_valid;
    logic [ENTRY_W-1:0]   r_data;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];

    logic                 w_run;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_limit;
    logic                 w_rdwr;
    logic [NUM_WATCH-1:0] w_hit;
    logic [ENTRY_W-1:0]   w_entry;

    // The arm cycle suppresses capture and pops so the restarted run begins clean.
    assign w_run   = (r_state == ST_RUN) && !arm;
    assign w_push  = w_run && (CTRLBUS != 2'b00);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = trace_rd && !w_empty && !arm;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_rdwr  = (CTRLBUS == 2'b01) || (CTRLBUS == 2'b10);
    assign w_limit = (cycle_limit != {CNT_W{1'b0}}) && ((r_cyc + CNT_W'(1)) == cycle_limit);

`ifdef TRACE_TIMESTAMP_EN
    assign w_entry = {r_cyc[TS_W-1:0], CTRLBUS, ADDRBUS, DATABUS};
`else
    assign w_entry = {CTRLBUS, ADDRBUS, DATABUS};
`endif

    // Per-channel address compare; illegal cycles never qualify as hits.
    always_comb begin
        w_hit = {NUM_WATCH{1'b0}};
        for (int i = 0; i < NUM_WATCH; i++) begin
            if (w_run && watch_en[i] && w_rdwr && (ADDRBUS == watch_addr[i*ADDR_W +: ADDR_W])) begin
                w_hit[i] = 1'b1;
            end else begin
                w_hit[i] = 1'b0;
            end
        end
    end

    // Trace storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clkR) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    // Control FSM, counters, FIFO pointers and registered read port.
    always_ff @(posedge clkR) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cyc       <= {CNT_W{1'b0}};
            r_rd_count  <= {CNT_W{1'b0}};
            r_wr_count  <= {CNT_W{1'b0}};
            r_err_count <= {CNT_W{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_overflow  <= 1'b0;
            r_watch_hit <= {NUM_WATCH{1'b0}};
            r_valid     <= 1'b0;
            r_data      <= {ENTRY_W{1'b0}};
        end else if (arm) begin
            r_state     <= ST_RUN;
            r_cyc       <= {CNT_W{1'b0}};
            r_rd_count  <= {CNT_W{1'b0}};
            r_wr_count  <= {CNT_W{1'b0}};
            r_err_count <= {CNT_W{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_overflow  <= 1'b0;
            r_watch_hit <= {NUM_WATCH{1'b0}};
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_watch_hit <= r_watch_hit | w_hit;
            case (r_state)
                ST_RUN: begin
                    r_cyc <= r_cyc + CNT_W'(1);
                    case (CTRLBUS)
                        2'b01: if (r_rd_count != {CNT_W{1'b1}}) r_rd_count <= r_rd_count + CNT_W'(1);
                        2'b10: if (r_wr_count != {CNT_W{1'b1}}) r_wr_count <= r_wr_count + CNT_W'(1);
                        2'b11: if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
                        default: ;
                    endcase
                    if (w_limit || (halt_on_watch && (|w_hit))) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_IDLE: r_state <= ST_IDLE;
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign trace_valid = r_valid;
    assign trace_data  = r_data;
    assign trace_empty = w_empty;
    assign overflow    = r_overflow;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign err_count   = r_err_count;
    assign watch_hit   = r_watch_hit;
    assign running     = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// Directed self-checking bench for cpu_bus_tracer (default parameters).
module tb_cpu_bus_tracer;
    localparam int EW = 34;
`ifdef TRACE_TIMESTAMP_EN
    localparam int TW = EW + 16;
`else
    localparam int TW = EW;
`endif

    logic          clkR = 1'b0;
    logic          reset;
    logic [15:0]   ADDRBUS;
    logic [1:0]    CTRLBUS;
    logic [15:0]   DATABUS;
    logic          arm;
    logic [31:0]   cycle_limit;
    logic [31:0]   watch_addr;
    logic [1:0]    watch_en;
    logic          halt_on_watch;
    logic          trace_rd;
    logic          trace_valid;
    logic [TW-1:0] trace_data;
    logic          trace_empty;
    logic          overflow;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
    logic [31:0]   err_count;
    logic [1:0]    watch_hit;
    logic          running;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_tracer dut (
        .clkR(clkR), .reset(reset), .ADDRBUS(ADDRBUS), .CTRLBUS(CTRLBUS), .DATABUS(DATABUS),
        .arm(arm), .cycle_limit(cycle_limit), .watch_addr(watch_addr), .watch_en(watch_en),
        .halt_on_watch(halt_on_watch), .trace_rd(trace_rd), .trace_valid(trace_valid),
        .trace_data(trace_data), .trace_empty(trace_empty), .overflow(overflow),
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
        .watch_hit(watch_hit), .running(running), .done(done)
    );

    always #5 clkR = ~clkR;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkR);
        #1;
    endtask

    task automatic bus(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
        CTRLBUS = c; ADDRBUS = a; DATABUS = d;
        tick();
        CTRLBUS = 2'b00;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    function automatic logic [63:0] ent(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
        return {30'd0, c, a, d};
    endfunction

    function automatic logic [63:0] payload(input logic [TW-1:0] t);
        return {30'd0, t[EW-1:0]};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_running"}, 64'(running), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_empty"}, 64'(trace_empty), 64'd1);
        check({tag, "_valid"}, 64'(trace_valid), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_hit"}, 64'(watch_hit), 64'd0);
        check({tag, "_rd"}, 64'(rd_count), 64'd0);
        check({tag, "_wr"}, 64'(wr_count), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
        check({tag, "_data"}, 64'(trace_data), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; ADDRBUS = 16'h0000; CTRLBUS = 2'b00; DATABUS = 16'h0000;
        arm = 1'b0; cycle_limit = 32'd0; watch_addr = 32'h0000_0000; watch_en = 2'b00;
        halt_on_watch = 1'b0; trace_rd = 1'b0;
        tick(); tick();
        check_reset("rst");
        reset = 1'b0;
        tick();

        // cycle limit of 10 with an idle bus
        cycle_limit = 32'd10;
        do_arm();
        n = 0;
        while (running && n < 50) begin
            n++;
            tick();
        end
        check("limit_run_cycles", 64'(n), 64'd10);
        check("limit_done", 64'(done), 64'd1);
        check("limit_rd", 64'(rd_count), 64'd0);
        check("limit_wr", 64'(wr_count), 64'd0);
        check("limit_err", 64'(err_count), 64'd0);
        check("limit_empty", 64'(trace_empty), 64'd1);

        // one read, one write, drained in order
        cycle_limit = 32'd0;
        do_arm();
        bus(2'b01, 16'h0010, 16'h1234);
        bus(2'b10, 16'h0020, 16'hBEEF);
        trace_rd = 1'b1;
        tick();
        check("rw_valid0", 64'(trace_valid), 64'd1);
        check("rw_entry0", payload(trace_data), ent(2'b01, 16'h0010, 16'h1234));
        tick();
        check("rw_valid1", 64'(trace_valid), 64'd1);
        check("rw_entry1", payload(trace_data), ent(2'b10, 16'h0020, 16'hBEEF));
        tick();
        check("rw_pop_empty_valid", 64'(trace_valid), 64'd0);
        check("rw_data_hold", payload(trace_data), ent(2'b10, 16'h0020, 16'hBEEF));
        trace_rd = 1'b0;
        check("rw_rd_count", 64'(rd_count), 64'd1);
        check("rw_wr_count", 64'(wr_count), 64'd1);

        // 20 writes into 16 entries: first 16 kept
        do_arm();
        for (int i = 0; i < 20; i++) bus(2'b10, 16'(i), 16'hA000 + 16'(i));
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_wr_count", 64'(wr_count), 64'd20);
        trace_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("ovf_entry%0d", i), payload(trace_data), ent(2'b10, 16'(i), 16'hA000 + 16'(i)));
        end
        tick();
        check("ovf_drained_valid", 64'(trace_valid), 64'd0);
        check("ovf_drained_empty", 64'(trace_empty), 64'd1);
        trace_rd = 1'b0;

        // full FIFO with push and pop together: nothing dropped
        do_arm();
        for (int i = 0; i < 16; i++) bus(2'b10, 16'(i), 16'hB000 + 16'(i));
        check("full_no_ovf", 64'(overflow), 64'd0);
        trace_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus(2'b10, 16'h0100 + 16'(i), 16'hC000 + 16'(i));
            check($sformatf("pp_pop%0d", i), payload(trace_data), ent(2'b10, 16'(i), 16'hB000 + 16'(i)));
        end
        trace_rd = 1'b0;
        check("pp_no_ovf", 64'(overflow), 64'd0);
        bus(2'b10, 16'h0200, 16'hDDDD);
        check("pp_extra_ovf", 64'(overflow), 64'd1);
        trace_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("pp_entry%0d", i), payload(trace_data), ent(2'b10, 16'h0100 + 16'(i), 16'hC000 + 16'(i)));
        end
        tick();
        check("pp_empty", 64'(trace_empty), 64'd1);
        trace_rd = 1'b0;

        // watch hit on channel 0 halts the run; channel 1 disabled
        watch_addr = {16'h00FF, 16'h00FF};
        watch_en = 2'b01;
        halt_on_watch = 1'b1;
        do_arm();
        bus(2'b01, 16'h00FE, 16'h1111);
        for (int i = 0; i < 4; i++) bus(2'b00, 16'h00FF, 16'h0000);
        check("wh_pre_running", 64'(running), 64'd1);
        check("wh_pre_hit", 64'(watch_hit), 64'd0);
        bus(2'b01, 16'h00FF, 16'h5555);
        check("wh_hit", 64'(watch_hit), 64'd1);
        check("wh_done", 64'(done), 64'd1);
        check("wh_rd_count", 64'(rd_count), 64'd2);
        trace_rd = 1'b1;
        tick();
        check("wh_entry0", payload(trace_data), ent(2'b01, 16'h00FE, 16'h1111));
        tick();
        check("wh_entry1", payload(trace_data), ent(2'b01, 16'h00FF, 16'h5555));
        trace_rd = 1'b0;
        bus(2'b10, 16'h0033, 16'h3333);
        check("done_no_count", 64'(wr_count), 64'd0);
        check("done_no_capture", 64'(trace_empty), 64'd1);

        // illegal cycle at watched address: counted and traced, no hit
        do_arm();
        check("ill_hit_cleared", 64'(watch_hit), 64'd0);
        bus(2'b11, 16'h00FF, 16'h0BAD);
        check("ill_err", 64'(err_count), 64'd1);
        check("ill_no_hit", 64'(watch_hit), 64'd0);
        check("ill_running", 64'(running), 64'd1);
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        check("ill_entry", payload(trace_data), ent(2'b11, 16'h00FF, 16'h0BAD));

        // arm with a pending pop discards FIFO and drops the pop
        bus(2'b01, 16'h0030, 16'h0001);
        arm = 1'b1; trace_rd = 1'b1;
        tick();
        arm = 1'b0; trace_rd = 1'b0;
        check("arm_pop_valid", 64'(trace_valid), 64'd0);
        check("arm_pop_empty", 64'(trace_empty), 64'd1);
        check("arm_pop_rd", 64'(rd_count), 64'd0);

        // reset in the middle of a run
        bus(2'b10, 16'h0040, 16'h4444);
        bus(2'b11, 16'h0041, 16'h4445);
        watch_en = 2'b11;
        bus(2'b01, 16'h00FF, 16'h4446);
        reset = 1'b1;
        tick();
        check_reset("midrst");
        reset = 1'b0;
        tick();

`ifdef TRACE_TIMESTAMP_EN
        // timestamp equals run cycle index at push
        watch_en = 2'b00;
        do_arm();
        for (int i = 0; i < 3; i++) bus(2'b00, 16'h0000, 16'h0000);
        bus(2'b10, 16'h0050, 16'h5050);
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        check("ts_value", 64'(trace_data[TW-1:EW]), 64'd3);
        check("ts_payload", payload(trace_data), ent(2'b10, 16'h0050, 16'h5050));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_bus_tracer.md
Name: cpu_bus_tracer

Overview:
Parametrised debug block for the CPU bus. It snoops ADDRBUS/CTRLBUS/DATABUS every clkR cycle and counts read, write and illegal bus cycles. Captured transactions go into a trace FIFO that the host drains. The block flags address-watch hits and asserts done on a cycle limit or a watch hit, which lets a bench or on-chip debugger stop a run deterministically instead of waiting for a fixed long timeout.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 16, data bus width
DEPTH, 16, trace FIFO entries (power of two, >=2)
NUM_WATCH, 2, number of address-watch channels (1..8)
CNT_W, 32, width of cycle counter and event counters
TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)

Ports:
clkR  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ADDRBUS  in  ADDR_W  snooped address bus
CTRLBUS  in  2  snooped control: 00 none, 01 read, 10 write, 11 illegal
DATABUS  in  DATA_W  snooped data bus (sampled only, never driven)
arm  in  1  pulse: clear counters/FIFO/flags and start capture
cycle_limit  in  CNT_W  cycles to run after arm; 0 = unlimited
watch_addr  in  NUM_WATCH*ADDR_W  watch addresses, channel i at bits [i*ADDR_W +: ADDR_W]
watch_en  in  NUM_WATCH  per-channel watch enable
halt_on_watch  in  1  1 = a watch hit ends the run
trace_rd  in  1  pop request
trace_valid  out  1  trace_data valid this cycle
trace_data  out  2+ADDR_W+DATA_W(+TS_W)  {[TS,] ctrl, addr, data}
trace_empty  out  1  FIFO empty
overflow  out  1  sticky: a transaction was dropped
rd_count, wr_count, err_count  out  CNT_W each  saturating event counters
watch_hit  out  NUM_WATCH  sticky per-channel hit flags
running  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset: state IDLE. All counters, pointers and flags are 0. trace_valid=0, trace_data=0, trace_empty=1, overflow=0, watch_hit=0, running=0, done=0. Reset overrides all other inputs in the same cycle.
- States:
  - IDLE -(arm)-> RUN
  - RUN -(limit reached or qualifying watch hit)-> DONE
  - DONE -(arm)-> RUN
  - arm in RUN restarts the run: clear, stay RUN.
- Arm cycle: clears cyc, all counters, FIFO, overflow and watch_hit. Nothing is captured in the arm cycle. Capture starts on the next edge.
- RUN, each cycle:
  - cyc increments.
  - CTRLBUS 01 -> rd_count+1; 10 -> wr_count+1; 11 -> err_count+1. All counters saturate at all-ones.
  - Any non-00 CTRLBUS pushes {ctrl, ADDRBUS, DATABUS} into the FIFO. 11 is traced so illegal cycles can be inspected.
- Watch: in RUN, for each i with watch_en[i], a read or write (01/10) whose ADDRBUS equals channel i's address sets watch_hit[i]. CTRLBUS 11 never hits.
- Transition to DONE (evaluated at the end of the cycle):
  - if cycle_limit!=0 and cyc+1 == cycle_limit, or
  - if halt_on_watch and any watch_hit bit is set in this cycle.
  - The triggering cycle's transaction is still captured and counted.
  - DONE/IDLE: no capture, no counting, flags hold. FIFO remains readable.
- FIFO is registered-read:
  - trace_rd with !trace_empty -> trace_valid=1 and trace_data=head on the next cycle; else trace_valid=0 next cycle.
  - trace_data holds its last value when trace_valid=0.
- Full:
  - Push while full and no pop: entry dropped, overflow set (sticky until arm/reset).
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Pop when empty: ignored.
- Pointers are log2(DEPTH)+1 bits; wrap is natural. Full = MSBs differ and lower bits equal.
- arm while the FIFO is non-empty discards its contents. A pop requested in the arm cycle is dropped (trace_valid=0 next cycle).

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined: each entry is prefixed with cyc[TS_W-1:0] captured at push time, and trace_data widens by TS_W.
- Undefined: no timestamp field, and trace_data is 2+ADDR_W+DATA_W bits.

Test Plan:
- reset, arm, cycle_limit=10, CTRLBUS=00 throughout -> running for 10 cycles, then done=1; all counters 0; trace_empty=1.
- arm, then read @0x0010 data 0x1234, write @0x0020 data 0xBEEF, then pop x2 -> entries {01,0x0010,0x1234} and {10,0x0020,0xBEEF} in order; rd_count=1, wr_count=1.
- DEPTH=16, 20 consecutive writes, no pops -> overflow=1; exactly the first 16 entries are read back. Then 16 writes with simultaneous pop while full -> no further drops.
- watch_addr[0]=0x00FF, watch_en=01, halt_on_watch=1, read @0x00FF on run cycle 5 -> watch_hit=01; done the next cycle; the hit transaction is present in the FIFO.
- CTRLBUS=11 @0x00FF with watch on -> err_count=1, no watch hit, entry traced. Reset mid-run -> IDLE, all outputs at reset values.
- With TRACE_TIMESTAMP_EN: arm, write on run cycle 3 -> entry timestamp field = 3.
